// File: rtl/core_pkg.sv
// Shared types and constants for the core control path.
package core_pkg;

    localparam int unsigned SEQ_TIMEOUT_DEFAULT = 1024;

    typedef enum logic [2:0] {
        SEQ_IDLE   = 3'd0,
        SEQ_FETCH  = 3'd1,
        SEQ_DECODE = 3'd2,
        SEQ_EXEC   = 3'd3,
        SEQ_MEM    = 3'd4,
        SEQ_WB     = 3'd5,
        SEQ_TRAP   = 3'd6,
        SEQ_HALT   = 3'd7
    } seq_state_t;

    // True for the states that issue a stage start pulse and wait for its done.
    function automatic logic isStageState(input seq_state_t s);
        return s inside {SEQ_FETCH, SEQ_DECODE, SEQ_EXEC, SEQ_MEM, SEQ_WB, SEQ_TRAP};
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Per-stage watchdog: restarts on every stage start pulse, counts cycles
// spent waiting for the stage done and raises a sticky hang at the limit.
module seq_watchdog
    import core_pkg::*;
#(
    parameter int unsigned TIMEOUT = SEQ_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_restart,
    input  logic i_waiting,
    input  logic i_done,
    output logic o_expire,
    output logic o_hang
);

    logic [31:0] r_count;
    logic        r_hang;

    // The count is 1 in the first waiting cycle, so the limit is hit exactly TIMEOUT cycles after the pulse.
    assign o_expire = i_waiting && !i_done && !r_hang && (r_count == TIMEOUT - 1);
    assign o_hang   = r_hang;

    // Count waiting cycles since the last start pulse; latch hang until reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_count <= '0;
            r_hang  <= 1'b0;
        end else begin
            if (i_restart) begin
                r_count <= 32'd1;
            end else if (i_waiting && !o_expire) begin
                r_count <= r_count + 32'd1;
            end
            if (o_expire) begin
                r_hang <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: pulses each stage enable, waits for the
// stage done, skips MEM for non-memory ops, diverts to TRAP on exceptions and
// counts retired instructions. Define SEQ_WATCHDOG_EN to build the stage watchdog.
module core_sequencer
    import core_pkg::*;
#(
    parameter int unsigned TIMEOUT = SEQ_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        halt_req,
    output logic        fetch_en,
    output logic        decode_en,
    output logic        exec_en,
    output logic        mem_en,
    output logic        wb_en,
    output logic        trap_en,
    input  logic        fetch_done,
    input  logic        decode_done,
    input  logic        exec_done,
    input  logic        mem_done,
    input  logic        wb_done,
    input  logic        trap_done,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        trap_req,
    output logic        busy,
    output seq_state_t  state,
    output logic [63:0] instret,
    output logic        hang
);

    seq_state_t  r_state;
    seq_state_t  w_nextState;
    logic        r_issued;
    logic [63:0] r_instret;
    logic        w_stageDone;
    logic        w_sampled;
    logic        w_expire;
    logic        w_hang;

    // Select the done belonging to the current stage; other stages' dones are ignored.
    always_comb begin
        w_stageDone = 1'b0;
        case (r_state)
            SEQ_FETCH:  w_stageDone = fetch_done;
            SEQ_DECODE: w_stageDone = decode_done;
            SEQ_EXEC:   w_stageDone = exec_done;
            SEQ_MEM:    w_stageDone = mem_done;
            SEQ_WB:     w_stageDone = wb_done;
            SEQ_TRAP:   w_stageDone = trap_done;
            default:    w_stageDone = 1'b0;
        endcase
    end

    // A done only counts after the entry cycle, so one seen alongside the enable is dropped.
    assign w_sampled = r_issued && w_stageDone;

    // Stage enables fire only in the entry cycle and never while reset is held.
    always_comb begin
        fetch_en  = 1'b0;
        decode_en = 1'b0;
        exec_en   = 1'b0;
        mem_en    = 1'b0;
        wb_en     = 1'b0;
        trap_en   = 1'b0;
        if (rstn && !r_issued) begin
            case (r_state)
                SEQ_FETCH:  fetch_en  = 1'b1;
                SEQ_DECODE: decode_en = 1'b1;
                SEQ_EXEC:   exec_en   = 1'b1;
                SEQ_MEM:    mem_en    = 1'b1;
                SEQ_WB:     wb_en     = 1'b1;
                SEQ_TRAP:   trap_en   = 1'b1;
                default:    ;
            endcase
        end
    end

    // Next-state selection; an exception outranks the memory flags, a watchdog expiry outranks everything.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            SEQ_IDLE:   if (start) w_nextState = SEQ_FETCH;
            SEQ_FETCH:  if (w_sampled) w_nextState = SEQ_DECODE;
            SEQ_DECODE: if (w_sampled) w_nextState = SEQ_EXEC;
            SEQ_EXEC: begin
                if (w_sampled) begin
                    if (trap_req)                w_nextState = SEQ_TRAP;
                    else if (is_load || is_store) w_nextState = SEQ_MEM;
                    else                          w_nextState = SEQ_WB;
                end
            end
            SEQ_MEM:    if (w_sampled) w_nextState = SEQ_WB;
            SEQ_WB:     if (w_sampled) w_nextState = halt_req ? SEQ_HALT : SEQ_FETCH;
            SEQ_TRAP:   if (w_sampled) w_nextState = SEQ_FETCH;
            SEQ_HALT:   if (!start && !w_hang) w_nextState = SEQ_IDLE;
            default:    w_nextState = SEQ_IDLE;
        endcase
        if (w_expire) begin
            w_nextState = SEQ_HALT;
        end
    end

    // State, issued flag and retire counter; issued clears whenever the state changes.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= SEQ_IDLE;
            r_issued  <= 1'b0;
            r_instret <= '0;
        end else begin
            r_state  <= w_nextState;
            r_issued <= isStageState(r_state) && (w_nextState == r_state);
            if (r_state == SEQ_WB && w_sampled) begin
                r_instret <= r_instret + 64'd1;
            end
        end
    end

`ifdef SEQ_WATCHDOG_EN
    seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rstn      (rstn),
        .i_restart (fetch_en | decode_en | exec_en | mem_en | wb_en | trap_en),
        .i_waiting (r_issued),
        .i_done    (w_stageDone),
        .o_expire  (w_expire),
        .o_hang    (w_hang)
    );
`else
    assign w_expire = 1'b0;
    assign w_hang   = 1'b0;
    // The limit only has meaning when the watchdog is built.
    if (TIMEOUT == 0) begin : gNoLimit
    end
`endif

    assign busy    = (r_state != SEQ_IDLE) && (r_state != SEQ_HALT);
    assign state   = r_state;
    assign instret = r_instret;
    assign hang    = w_hang;

endmodule

// File: tb/tb_core_sequencer.sv
// Testbench for core_sequencer: table-driven instruction vectors with a
// stage-enable scoreboard, plus hand-written reset and watchdog sequences.
module tb_core_sequencer;
    import core_pkg::*;

`ifdef SEQ_WATCHDOG_EN
    localparam int unsigned TB_TIMEOUT = 16;
`else
    localparam int unsigned TB_TIMEOUT = SEQ_TIMEOUT_DEFAULT;
`endif

    localparam int ST_FETCH  = 0;
    localparam int ST_DECODE = 1;
    localparam int ST_EXEC   = 2;
    localparam int ST_MEM    = 3;
    localparam int ST_WB     = 4;
    localparam int ST_TRAP   = 5;

    typedef struct {
        logic isLoad;
        logic isStore;
        logic trapReq;
        logic halt;
        int   memDelay;
        int   expPeriod;
        int   expRetire;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic        halt_req;
    logic        is_load;
    logic        is_store;
    logic        trap_req;
    logic [5:0]  enVec;
    logic [5:0]  doneVec = 6'b0;
    logic        busy;
    logic        hang;
    seq_state_t  state;
    logic [63:0] instret;

    int checks = 0;
    int errors = 0;
    int expQ[$];
    int doneDelay[6];
    int pendStage = -1;
    int pendCnt = 0;
    vec_t vecs[8];

    core_sequencer #(
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .halt_req    (halt_req),
        .fetch_en    (enVec[0]),
        .decode_en   (enVec[1]),
        .exec_en     (enVec[2]),
        .mem_en      (enVec[3]),
        .wb_en       (enVec[4]),
        .trap_en     (enVec[5]),
        .fetch_done  (doneVec[0]),
        .decode_done (doneVec[1]),
        .exec_done   (doneVec[2]),
        .mem_done    (doneVec[3]),
        .wb_done     (doneVec[4]),
        .trap_done   (doneVec[5]),
        .is_load     (is_load),
        .is_store    (is_store),
        .trap_req    (trap_req),
        .busy        (busy),
        .state       (state),
        .instret     (instret),
        .hang        (hang)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int enIndex(input logic [5:0] v);
        for (int i = 0; i < 6; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic waitEn(input int idx, input int maxCycles, output int cycles, output bit ok);
        cycles = 0;
        ok = 1'b0;
        while (cycles < maxCycles && !ok) begin
            @(negedge clk);
            cycles++;
            if (enVec[idx]) ok = 1'b1;
        end
    endtask

    // Drive one instruction's flags and queue the enables it should produce after fetch.
    task automatic applyStimulus(input vec_t v);
        halt_req = v.halt;
        is_load  = v.isLoad;
        is_store = v.isStore;
        trap_req = v.trapReq;
        doneDelay[ST_MEM] = v.memDelay;
        expQ.push_back(ST_DECODE);
        expQ.push_back(ST_EXEC);
        if (v.trapReq) begin
            expQ.push_back(ST_TRAP);
        end else begin
            if (v.isLoad || v.isStore) expQ.push_back(ST_MEM);
            expQ.push_back(ST_WB);
        end
        if (!v.halt) expQ.push_back(ST_FETCH);
    endtask

    // Stage responder: raise the matching done doneDelay cycles after each enable.
    always @(negedge clk) begin
        doneVec = 6'b0;
        if (pendStage >= 0) begin
            if (pendCnt <= 0) begin
                doneVec[pendStage] = 1'b1;
                pendStage = -1;
            end else begin
                pendCnt = pendCnt - 1;
            end
        end
        for (int i = 0; i < 6; i++) begin
            if (enVec[i]) begin
                pendStage = i;
                pendCnt   = doneDelay[i] - 1;
            end
        end
    end

    // Scoreboard: every enable pulse must be one-hot and match the next queued stage.
    always @(negedge clk) begin : monitor
        int expStage;
        if (enVec != 6'b0) begin
            checkOutput("enOneHot", 64'($countones(enVec)), 64'd1);
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL enOrder: got en index %0d, expected none", enIndex(enVec));
            end else begin
                expStage = expQ.pop_front();
                checkOutput("enOrder", 64'(enIndex(enVec)), 64'(expStage));
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL globalTimeout: got no finish, expected finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        int          cyc;
        bit          ok;
        bit          lateBad;
        logic [63:0] expInstret;
        vec_t        memVec;

        vecs[0] = '{isLoad: 0, isStore: 0, trapReq: 0, halt: 0, memDelay: 1, expPeriod: 8,  expRetire: 1};
        vecs[1] = '{isLoad: 1, isStore: 0, trapReq: 0, halt: 0, memDelay: 5, expPeriod: 14, expRetire: 1};
        vecs[2] = '{isLoad: 0, isStore: 1, trapReq: 0, halt: 0, memDelay: 1, expPeriod: 10, expRetire: 1};
        vecs[3] = '{isLoad: 0, isStore: 1, trapReq: 1, halt: 0, memDelay: 1, expPeriod: 8,  expRetire: 0};
        vecs[4] = '{isLoad: 1, isStore: 0, trapReq: 1, halt: 0, memDelay: 3, expPeriod: 8,  expRetire: 0};
        vecs[5] = '{isLoad: 0, isStore: 0, trapReq: 0, halt: 0, memDelay: 1, expPeriod: 8,  expRetire: 1};
        vecs[6] = '{isLoad: 1, isStore: 0, trapReq: 0, halt: 0, memDelay: 2, expPeriod: 11, expRetire: 1};
        vecs[7] = '{isLoad: 0, isStore: 0, trapReq: 0, halt: 1, memDelay: 1, expPeriod: 8,  expRetire: 1};

        rstn     = 1'b0;
        start    = 1'b1;
        halt_req = 1'b0;
        is_load  = 1'b0;
        is_store = 1'b0;
        trap_req = 1'b0;
        for (int i = 0; i < 6; i++) doneDelay[i] = 1;

        // Reset held with start high: nothing may be issued.
        repeat (3) @(negedge clk);
        checkOutput("resetEn", 64'(enVec), 64'd0);
        checkOutput("resetInstret", instret, 64'd0);
        checkOutput("resetBusy", 64'(busy), 64'd0);
        checkOutput("resetState", 64'(state), 64'(SEQ_IDLE));
        checkOutput("resetHang", 64'(hang), 64'd0);

        expQ.push_back(ST_FETCH);
        rstn = 1'b1;
        @(negedge clk);
        checkOutput("releaseFetchEn", 64'(enVec[ST_FETCH]), 64'd1);

        // Instruction vectors, each started at its fetch pulse.
        expInstret = 64'd0;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(vecs[k]);
            expInstret += 64'(vecs[k].expRetire);
            if (!vecs[k].halt) begin
                waitEn(ST_FETCH, 100, cyc, ok);
                checkOutput($sformatf("nextFetch%0d", k), 64'(ok), 64'd1);
                checkOutput($sformatf("period%0d", k), 64'(cyc), 64'(vecs[k].expPeriod));
                checkOutput($sformatf("instret%0d", k), instret, expInstret);
            end else begin
                cyc = 0;
                while (cyc < 100 && state != SEQ_HALT) begin
                    @(negedge clk);
                    cyc++;
                end
                checkOutput("haltState", 64'(state), 64'(SEQ_HALT));
                checkOutput("haltCycles", 64'(cyc), 64'(vecs[k].expPeriod));
                checkOutput("haltInstret", instret, expInstret);
                checkOutput("haltBusy", 64'(busy), 64'd0);
            end
        end

        // HALT holds while start stays high, then returns to IDLE once start drops.
        repeat (3) @(negedge clk);
        checkOutput("haltHold", 64'(state), 64'(SEQ_HALT));
        start    = 1'b0;
        halt_req = 1'b0;
        @(negedge clk);
        checkOutput("haltToIdle", 64'(state), 64'(SEQ_IDLE));

        // Reset while waiting on a slow memory stage; the late mem_done must be ignored.
        start = 1'b1;
        expQ.push_back(ST_FETCH);
        waitEn(ST_FETCH, 10, cyc, ok);
        checkOutput("memTestFetch", 64'(ok), 64'd1);
        memVec = '{isLoad: 1, isStore: 0, trapReq: 0, halt: 0, memDelay: 12, expPeriod: 0, expRetire: 0};
        applyStimulus(memVec);
        waitEn(ST_MEM, 20, cyc, ok);
        checkOutput("memTestMemEn", 64'(ok), 64'd1);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        checkOutput("midResetState", 64'(state), 64'(SEQ_IDLE));
        checkOutput("midResetEn", 64'(enVec), 64'd0);
        checkOutput("midResetBusy", 64'(busy), 64'd0);
        checkOutput("midResetInstret", instret, 64'd0);
        expQ.delete();
        rstn = 1'b1;
        lateBad = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (enVec != 6'b0 || state != SEQ_IDLE) lateBad = 1'b1;
        end
        checkOutput("lateMemDoneIgnored", 64'(lateBad), 64'd0);
        checkOutput("lateInstret", instret, 64'd0);

`ifdef SEQ_WATCHDOG_EN
        // Decode never completes: hang must rise exactly TIMEOUT cycles after decode_en.
        is_load = 1'b0;
        doneDelay[ST_DECODE] = 1000;
        start = 1'b1;
        expQ.push_back(ST_FETCH);
        expQ.push_back(ST_DECODE);
        waitEn(ST_FETCH, 10, cyc, ok);
        checkOutput("wdFetch", 64'(ok), 64'd1);
        waitEn(ST_DECODE, 10, cyc, ok);
        checkOutput("wdDecode", 64'(ok), 64'd1);
        repeat (15) @(negedge clk);
        checkOutput("wdHangEarly", 64'(hang), 64'd0);
        @(negedge clk);
        checkOutput("wdHang", 64'(hang), 64'd1);
        checkOutput("wdState", 64'(state), 64'(SEQ_HALT));
        checkOutput("wdBusy", 64'(busy), 64'd0);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("wdHaltBlocked", 64'(state), 64'(SEQ_HALT));
`endif

        checkOutput("queueDrained", 64'(expQ.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control FSM for the RV32IM core. It runs one instruction at a time through the fetch, decode, execute, memory and writeback stages. It drives each stage's one-cycle `*_en` pulse and waits for that stage's `*_done`. It skips the memory stage for non-load/store instructions, diverts to a trap sequence on exceptions, and counts retired instructions. It sits at the core top level between the stage modules and the CSR unit.

## Interface
- `TIMEOUT`, 1024: watchdog limit, in cycles, for any single stage (used only with the watchdog macro).
- `clk`  in  1  core clock
- `rstn`  in  1  reset, synchronous, active-low
- `start`  in  1  level; leaves IDLE when high
- `halt_req`  in  1  level; sampled at writeback completion
- `fetch_en`, `decode_en`, `exec_en`, `mem_en`, `wb_en`, `trap_en`  out  1 each  one-cycle stage start pulses
- `fetch_done`, `decode_done`, `exec_done`, `mem_done`, `wb_done`, `trap_done`  in  1 each  stage completion levels
- `is_load`, `is_store`  in  1 each  decoded control flags, valid from `decode_done` onward
- `trap_req`  in  1  exception raised by execute, valid with `exec_done`
- `busy`  out  1  high in every state except IDLE and HALT
- `state`  out  seq_state_t  current FSM state
- `instret`  out  64  retired-instruction count
- `hang`  out  1  watchdog fired (watchdog builds only; tied 0 otherwise)

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP, HALT.
- Each stage state has an internal `issued` flag.
  - Entry cycle: the matching `*_en` is 1 and `issued` is set.
  - Later cycles: `*_en` is 0 and the FSM waits for `*_done`.
- `*_done` is sampled only when `issued`=1 and the matching `*_en`=0. Done seen during the en cycle is ignored. Done from a non-current stage is ignored.
- Transitions (all taken on the sampled done):
  - IDLE→FETCH when `start`=1.
  - FETCH→DECODE.
  - DECODE→EXEC.
  - EXEC→TRAP if `trap_req`=1.
  - EXEC→MEM if `is_load|is_store`.
  - EXEC→WB otherwise.
  - MEM→WB.
  - WB→HALT if `halt_req`=1, else WB→FETCH.
  - TRAP→FETCH.
  - HALT→IDLE when `start`=0.
- `trap_req` has priority over `is_load`/`is_store`.
- `instret` increments by 1 on each sampled `wb_done`. It wraps 2^64-1 → 0. Trapped instructions do not retire.
- At most one `*_en` is high in any cycle.

## Timing
- Reset (any cycle, including mid-instruction):
  - next state is IDLE and `issued` is cleared;
  - all `*_en` = 0, `busy` = 0, `instret` = 0, `hang` = 0.
- While `rstn`=0, no `*_en` is asserted.
- The next stage's `*_en` rises in the cycle after the sampled done.
- With single-cycle stages (done high in the cycle after en), each stage occupies 2 cycles.
  - ALU instruction: 8 cycles from `fetch_en` to the next `fetch_en`.
  - Load/store: 10 cycles.
- `instret` updates on the clock edge that samples `wb_done`.

## Configuration
- `SEQ_WATCHDOG_EN` defined:
  - A counter restarts at each `*_en` and counts waiting cycles.
  - Reaching `TIMEOUT` without the done sets `hang`=1 (sticky until reset) and moves the FSM to HALT.
  - `hang` is cleared only by reset. While `hang`=1, HALT→IDLE is blocked.
- Not defined: no counter is built and `hang` is constant 0.

## Structure
- `core_pkg` holds:
  - `seq_state_t`, the enum of the 8 states;
  - the `SEQ_TIMEOUT_DEFAULT` constant.
- One sub-module, `seq_watchdog` (counter plus compare), instantiated only under `SEQ_WATCHDOG_EN`.

## Test plan
- **Reset:** reset held, `start`=1 → all `*_en`=0, `instret`=0. After release with `start`=1 → `fetch_en` the next cycle.
- **ALU instruction:** `is_load`=`is_store`=0, every done 1 cycle after its en → en order fetch, decode, exec, wb. No `mem_en`. 8-cycle period. `instret` 0→1.
- **Load:** `is_load`=1, `mem_done` delayed 5 cycles → `mem_en` is a single pulse, `wb_en` the cycle after `mem_done`. `instret`+1.
- **Trap:** `trap_req`=1 and `is_store`=1 with `exec_done` → `trap_en` (not `mem_en`), then `fetch_en` after `trap_done`. `instret` unchanged.
- **Reset mid-MEM:** `rstn`=0 while waiting for `mem_done` → IDLE. A late `mem_done` is ignored. `instret`=0.
- **Watchdog (`SEQ_WATCHDOG_EN`, `TIMEOUT`=16):** `decode_done` never asserted → `hang`=1 16 cycles after `decode_en`, state HALT, `busy`=0.
